mfp_ahb_lite_decoder: RTL and testbench
=======================================

Name: mfp_ahb_lite_decoder

Overview:
- Single-master AHB-Lite address decoder and response multiplexer, sitting between the CPU master port and up to three slaves; slave 0 is the wait-stating RAM.
- Address phase: drives each slave's HSEL and drives the shared HREADY to the master and to all slaves.
- Data phase: muxes HRDATA/HRESP/HREADYOUT back from whichever slave owns it.
- Contains a built-in default slave (two-cycle ERROR for unmapped addresses) and a sticky wait-state watchdog.

Parameters:
- S0_BASE, 32'h0000_0000, slave 0 base address (RAM)
- S0_MASK, 32'hFFFF_0000, slave 0 address mask
- S1_BASE, 32'h1F80_0000, slave 1 base address (GPIO)
- S1_MASK, 32'hFFFF_0000, slave 1 address mask
- S2_BASE, 32'h1FC0_0000, slave 2 base address (boot ROM)
- S2_MASK, 32'hFFC0_0000, slave 2 address mask
- TIMEOUT_CYCLES, 64, consecutive HREADY-low cycles before HTIMEOUT sets; range 2..65535

Ports:
- HCLK  in  1  bus clock; all state on rising edge
- HRESET  in  1  synchronous, active-high reset
- HADDR  in  32  master address
- HTRANS  in  2  master transfer type
- HREADY  out  1  shared ready to master and all slaves
- HRDATA  out  32  read data to master
- HRESP  out  1  response to master
- HTIMEOUT  out  1  sticky watchdog flag
- HSEL_S0 / HSEL_S1 / HSEL_S2  out  1 each  slave selects
- HRDATA_S0 / HRDATA_S1 / HRDATA_S2  in  32 each  slave read data
- HREADYOUT_S0 / HREADYOUT_S1 / HREADYOUT_S2  in  1 each  slave ready
- HRESP_S0 / HRESP_S1 / HRESP_S2  in  1 each  slave response

Behaviour:
- Clocking and reset: one clock, HCLK. Reset is synchronous, active-high, on HRESET.
- Decode (combinational):
  - hit_x = ((HADDR & Sx_MASK) == Sx_BASE).
  - Priority S0 > S1 > S2; at most one HSEL_Sx high.
  - No hit selects the default slave (DEF).
  - HSEL is not qualified by HTRANS; slaves qualify with HTRANS/HREADY themselves.
- Data-phase select register dsel (S0, S1, S2, DEF):
  - Loads the decoded select on every cycle with HREADY=1.
  - Holds while HREADY=0.
  - Reset value DEF.
- Response mux by dsel:
  - HREADY = HREADYOUT_Sx, HRESP = HRESP_Sx, HRDATA = HRDATA_Sx.
  - For DEF: HREADY/HRESP come from the default-slave FSM and HRDATA = 32'h0.
- Default-slave FSM:
  - D_IDLE: readyout=1, resp=0. Goes to D_ERR1 when HREADY=1, decode=DEF and HTRANS[1]=1 (NONSEQ/SEQ); otherwise stays.
  - D_ERR1: readyout=0, resp=1. Always goes to D_ERR2.
  - D_ERR2: readyout=1, resp=1. Goes to D_ERR1 if HREADY=1, decode=DEF and HTRANS[1]=1; otherwise D_IDLE.
  - IDLE/BUSY transfers to unmapped addresses get a zero-wait OKAY.
- Watchdog: 16-bit counter.
  - Clears when HREADY=1; increments when HREADY=0; saturates.
  - HTIMEOUT sets in the cycle after the counter reaches TIMEOUT_CYCLES-1 with HREADY still 0.
  - HTIMEOUT stays set until HRESET. The watchdog never forces HREADY.
- Reset values: dsel=DEF, FSM=D_IDLE, counter=0, HTIMEOUT=0. Hence HREADY=1, HRESP=0, HRDATA=0 in the cycle after HRESET is sampled high.
- Reset mid-transfer: the outstanding data phase is abandoned; the reset values above apply from the next edge.
- Back-to-back transfers across slaves:
  - The new address is decoded while the previous data phase completes.
  - dsel switches only at the edge where HREADY=1, so no data-phase glitching between slaves.
- Latency: zero added cycles; the decoder is transparent apart from the default slave's ERROR.

Test Plan:
- Reset: hold HRESET=1 for 2 cycles, release -> HREADY=1, HRESP=0, HRDATA=0, HTIMEOUT=0, all FSMs idle.
- Decode: HADDR=0x0000_0010 NONSEQ -> HSEL_S0=1 only. HADDR=0x1F80_0004 -> HSEL_S1=1 only. HADDR=0x1FC0_1000 -> HSEL_S2=1 only.
- RAM wait states: write 0xDEADBEEF to 0x0000_0008, then read it back with S0 inserting 3 wait cycles. Expect HREADY low exactly while HREADYOUT_S0 is low, HRDATA=0xDEADBEEF on the completing cycle, HRESP=0.
- Unmapped NONSEQ to 0x4000_0000: next cycle HREADY=0, HRESP=1; following cycle HREADY=1, HRESP=1; then OKAY. An IDLE to the same address -> no ERROR.
- Two unmapped NONSEQs back-to-back -> ERR1, ERR2, ERR1, ERR2, then D_IDLE.
- Watchdog and mid-transfer reset: TIMEOUT_CYCLES=4 with S1 holding HREADYOUT_S1=0 -> HTIMEOUT=1 after the 4th low cycle and stays 1. Assert HRESET while HREADY=0 -> next cycle HREADY=1, HTIMEOUT=0, dsel=DEF.

Source files
------------

// File: rtl/mfp_ahb_lite_decoder_if.sv
// AHB-Lite bus bundle between the CPU master port, the decoder and three slaves.
// The slave modport is the decoder's view; the master modport drives it.
interface mfp_ahb_lite_decoder_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        HTIMEOUT;
  logic        HSEL_S0;
  logic        HSEL_S1;
  logic        HSEL_S2;
  logic [31:0] HRDATA_S0;
  logic [31:0] HRDATA_S1;
  logic [31:0] HRDATA_S2;
  logic        HREADYOUT_S0;
  logic        HREADYOUT_S1;
  logic        HREADYOUT_S2;
  logic        HRESP_S0;
  logic        HRESP_S1;
  logic        HRESP_S2;

  modport slave (
    input  HADDR, HTRANS,
    input  HRDATA_S0, HRDATA_S1, HRDATA_S2,
    input  HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2,
    input  HRESP_S0, HRESP_S1, HRESP_S2,
    output HREADY, HRDATA, HRESP, HTIMEOUT,
    output HSEL_S0, HSEL_S1, HSEL_S2
  );

  modport master (
    output HADDR, HTRANS,
    output HRDATA_S0, HRDATA_S1, HRDATA_S2,
    output HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2,
    output HRESP_S0, HRESP_S1, HRESP_S2,
    input  HREADY, HRDATA, HRESP, HTIMEOUT,
    input  HSEL_S0, HSEL_S1, HSEL_S2
  );
endinterface

// File: rtl/mfp_ahb_lite_decoder.sv
// AHB-Lite address decoder / response mux for three slaves plus a
// built-in ERROR default slave and a sticky wait-state watchdog.
module mfp_ahb_lite_decoder #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S1_BASE = 32'h1F80_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S2_BASE = 32'h1FC0_0000,
  parameter logic [31:0] S2_MASK = 32'hFFC0_0000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                   HCLK,
  input logic                   HRESET,
  mfp_ahb_lite_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    SEL_S0, SEL_S1, SEL_S2, SEL_DEF
  } sel_e;

  typedef enum logic [1:0] {
    D_IDLE, D_ERR1, D_ERR2
  } dstate_e;

  localparam logic [15:0] WD_LAST =
    16'(TIMEOUT_CYCLES - 1);

  sel_e        dec;
  sel_e        dsel_d, dsel_q;
  dstate_e     dst_d, dst_q;
  logic [15:0] wd_d, wd_q;
  logic        tout_d, tout_q;
  logic        hit0, hit1, hit2;
  logic        hready, hresp;
  logic [31:0] hrdata;
  logic        def_req;

  always_comb begin
    hit0 = (bus.HADDR & S0_MASK) == S0_BASE;
    hit1 = (bus.HADDR & S1_MASK) == S1_BASE;
    hit2 = (bus.HADDR & S2_MASK) == S2_BASE;
    dec  = SEL_DEF;
    if (hit0)      dec = SEL_S0;
    else if (hit1) dec = SEL_S1;
    else if (hit2) dec = SEL_S2;
  end

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = 32'h0;
    unique case (dsel_q)
      SEL_S0: begin
        hready = bus.HREADYOUT_S0;
        hresp  = bus.HRESP_S0;
        hrdata = bus.HRDATA_S0;
      end
      SEL_S1: begin
        hready = bus.HREADYOUT_S1;
        hresp  = bus.HRESP_S1;
        hrdata = bus.HRDATA_S1;
      end
      SEL_S2: begin
        hready = bus.HREADYOUT_S2;
        hresp  = bus.HRESP_S2;
        hrdata = bus.HRDATA_S2;
      end
      SEL_DEF: begin
        hready = dst_q != D_ERR1;
        hresp  = dst_q != D_IDLE;
      end
    endcase
  end

  // Only active transfers to unmapped space earn the two-cycle ERROR.
  assign def_req = hready && (dec == SEL_DEF)
                   && bus.HTRANS[1];

  always_comb begin
    dst_d = dst_q;
    unique case (dst_q)
      D_IDLE:  if (def_req) dst_d = D_ERR1;
      D_ERR1:  dst_d = D_ERR2;
      D_ERR2:  dst_d = def_req ? D_ERR1 : D_IDLE;
      default: dst_d = D_IDLE;
    endcase
  end

  always_comb begin
    dsel_d = hready ? dec : dsel_q;
    wd_d   = wd_q;
    if (hready)               wd_d = 16'h0;
    else if (wd_q != 16'hFFFF) wd_d = wd_q + 16'd1;
    tout_d = tout_q
             | (!hready && (wd_q == WD_LAST));
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_q <= SEL_DEF;
      dst_q  <= D_IDLE;
      wd_q   <= 16'h0;
      tout_q <= 1'b0;
    end else begin
      dsel_q <= dsel_d;
      dst_q  <= dst_d;
      wd_q   <= wd_d;
      tout_q <= tout_d;
    end
  end

  assign bus.HREADY   = hready;
  assign bus.HRESP    = hresp;
  assign bus.HRDATA   = hrdata;
  assign bus.HTIMEOUT = tout_q;
  assign bus.HSEL_S0  = dec == SEL_S0;
  assign bus.HSEL_S1  = dec == SEL_S1;
  assign bus.HSEL_S2  = dec == SEL_S2;

endmodule

// File: tb/tb_mfp_ahb_lite_decoder.sv
// Scoreboard bench for mfp_ahb_lite_decoder: random and directed AHB
// transfers against behavioural slaves and an address-map reference.
module tb_mfp_ahb_lite_decoder;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;

  mfp_ahb_lite_decoder_if bus();

  mfp_ahb_lite_decoder #(.TIMEOUT_CYCLES(4)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int          waits;
    bit          err;
    logic        resp;
    bit          chkd;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   have;
  int   low;
  int   run;
  bit   tout_exp;
  bit   rst_q;
  int   checks;
  int   failures;

  bit [31:0] rmem[256];
  bit [31:0] smem[256];

  bit          act[3];
  int          wl[3];
  logic [31:0] dpa[3];
  bit          dpw[3];
  logic [31:0] dpd[3];
  int          nw;
  bit          hw;
  logic [31:0] hwd;

  logic [31:0] def_edges[6];
  logic [2:0]  sel_v;

  function automatic int region(logic [31:0] a);
    if (a < 32'h0001_0000) return 0;
    if (a >= 32'h1F80_0000 && a < 32'h1F81_0000) return 1;
    if (a >= 32'h1FC0_0000 && a < 32'h2000_0000) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] pat(int x, logic [31:0] a);
    return (x == 1) ? ~a : (a ^ 32'h5A5A_C3C3);
  endfunction

  task automatic check(string nm, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic exp_t ref_model(logic [31:0] a,
      logic [1:0] t, bit w, logic [31:0] wd, int waits);
    exp_t e;
    int   r;
    r = region(a);
    e.waits = 0;
    e.err   = 0;
    e.resp  = 1'b0;
    e.chkd  = 0;
    e.rdata = 32'h0;
    if (r == 3) begin
      e.chkd = 1;
      if (t[1]) begin
        e.err   = 1;
        e.waits = 1;
        e.resp  = 1'b1;
      end
    end else if (t[1]) begin
      e.waits = waits;
      if (w) begin
        if (r == 0) rmem[a[9:2]] = wd;
      end else begin
        e.chkd  = 1;
        e.rdata = (r == 0) ? rmem[a[9:2]] : pat(r, a);
      end
    end
    return e;
  endfunction

  // Behavioural slaves: fixed per-transfer wait count, then data.
  assign sel_v = {bus.HSEL_S2, bus.HSEL_S1, bus.HSEL_S0};

  always @(posedge HCLK) begin
    rst_q <= HRESET;
    if (HRESET) begin
      for (int i = 0; i < 3; i++) act[i] <= 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (act[i] && wl[i] != 0) begin
          wl[i] <= wl[i] - 1;
        end else if (act[i]) begin
          act[i] <= 0;
          if (i == 0 && dpw[0]) smem[dpa[0][9:2]] <= dpd[0];
        end
        if (bus.HREADY && sel_v[i] && bus.HTRANS[1]) begin
          act[i] <= 1;
          wl[i]  <= nw;
          dpa[i] <= bus.HADDR;
          dpw[i] <= hw;
          dpd[i] <= hwd;
        end
      end
    end
  end

  always_comb begin
    bus.HRDATA_S0    = act[0] ? smem[dpa[0][9:2]]
                              : 32'hBAD0_0000;
    bus.HRDATA_S1    = act[1] ? pat(1, dpa[1]) : 32'hBAD0_0001;
    bus.HRDATA_S2    = act[2] ? pat(2, dpa[2]) : 32'hBAD0_0002;
    bus.HREADYOUT_S0 = !(act[0] && wl[0] != 0);
    bus.HREADYOUT_S1 = !(act[1] && wl[1] != 0);
    bus.HREADYOUT_S2 = !(act[2] && wl[2] != 0);
    bus.HRESP_S0     = 1'b0;
    bus.HRESP_S1     = 1'b0;
    bus.HRESP_S2     = 1'b0;
  end

  // Monitor: pops one expectation per data phase.
  always @(negedge HCLK) begin
    logic [2:0] exp_sel;
    int         r;
    r = region(bus.HADDR);
    exp_sel = (r == 3) ? 3'b000 : 3'(1 << r);
    check("hsel", {29'h0, sel_v}, {29'h0, exp_sel});
    if (rst_q || HRESET) begin
      if (rst_q) begin
        check("rst_hready", {31'h0, bus.HREADY}, 32'h1);
        check("rst_hresp", {31'h0, bus.HRESP}, 32'h0);
        check("rst_hrdata", bus.HRDATA, 32'h0);
        check("rst_htimeout", {31'h0, bus.HTIMEOUT}, 32'h0);
      end
      q.delete();
      have = 0;
      low = 0;
      run = 0;
      tout_exp = 0;
    end else begin
      check("htimeout", {31'h0, bus.HTIMEOUT},
            {31'h0, tout_exp});
      if (!have && q.size() > 0) begin
        cur = q.pop_front();
        have = 1;
        low = 0;
      end
      if (have) begin
        if (!bus.HREADY) begin
          low++;
          check("wait_bound", {31'h0, low <= cur.waits}, 32'h1);
          if (cur.err)
            check("err1_hresp", {31'h0, bus.HRESP}, 32'h1);
        end else begin
          check("waits", low, cur.waits);
          check("hresp", {31'h0, bus.HRESP}, {31'h0, cur.resp});
          if (cur.chkd) check("hrdata", bus.HRDATA, cur.rdata);
          have = 0;
        end
      end
      if (bus.HREADY) run = 0;
      else run++;
      if (run >= 4) tout_exp = 1;
    end
  end

  // Issue one address phase, holding it until HREADY accepts it.
  task automatic xfer(logic [31:0] a, logic [1:0] t, bit w,
                      logic [31:0] wd, int waits);
    bit done;
    bus.HADDR  = a;
    bus.HTRANS = t;
    hw  = w;
    hwd = wd;
    nw  = waits;
    done = 0;
    for (int n = 0; n < 64 && !done; n++) begin
      #8;
      if (bus.HREADY && !HRESET) begin
        q.push_back(ref_model(a, t, w, wd, waits));
        done = 1;
      end
      @(posedge HCLK);
      #1;
    end
    if (!done) begin
      failures++;
      $display("FAIL xfer_timeout addr=%h got=no_accept exp=accept",
               a);
    end
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    checks = 0;
    failures = 0;
    def_edges[0] = 32'h0001_0000;
    def_edges[1] = 32'h1F7F_FFFC;
    def_edges[2] = 32'h1F81_0000;
    def_edges[3] = 32'h1FBF_FFFC;
    def_edges[4] = 32'h2000_0000;
    def_edges[5] = 32'hFFFF_FFFC;
    bus.HADDR  = 32'h0;
    bus.HTRANS = 2'b00;
    hw = 0;
    hwd = 32'h0;
    nw = 0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    xfer(32'h0000_0010, 2'b10, 0, 32'h0, 1);
    xfer(32'h1F80_0004, 2'b10, 0, 32'h0, 0);
    xfer(32'h1FC0_1000, 2'b10, 0, 32'h0, 2);
    xfer(32'h0000_0008, 2'b10, 1, 32'hDEAD_BEEF, 1);
    xfer(32'h0000_0008, 2'b10, 0, 32'h0, 3);
    xfer(32'h4000_0000, 2'b10, 0, 32'h0, 0);
    xfer(32'h4000_0000, 2'b00, 0, 32'h0, 0);
    xfer(32'h4000_0000, 2'b00, 0, 32'h0, 0);
    xfer(32'h4000_0000, 2'b10, 0, 32'h0, 0);
    xfer(32'h4000_0004, 2'b11, 0, 32'h0, 0);
    xfer(32'h4000_0000, 2'b00, 0, 32'h0, 0);
    xfer(32'h0000_0000, 2'b00, 0, 32'h0, 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: a = ($urandom_range(0, 7) == 0) ? 32'h0000_FFFC
             : 32'($urandom_range(0, 255) << 2);
        1: a = 32'h1F80_0000 | ($urandom & 32'h0000_FFFC);
        2: a = 32'h1FC0_0000 | ($urandom & 32'h003F_FFFC);
        default: a = ($urandom_range(0, 1) == 0)
             ? def_edges[$urandom_range(0, 5)]
             : 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
      endcase
      xfer(a, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), $urandom,
           $urandom_range(0, 3));
    end

    xfer(32'h1F80_0010, 2'b10, 0, 32'h0, 12);
    bus.HTRANS = 2'b00;
    repeat (5) @(posedge HCLK);
    #1;
    check("wd_hready_low", {31'h0, bus.HREADY}, 32'h0);
    check("wd_timeout_set", {31'h0, bus.HTIMEOUT}, 32'h1);
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    check("mid_rst_hready", {31'h0, bus.HREADY}, 32'h1);
    check("mid_rst_timeout", {31'h0, bus.HTIMEOUT}, 32'h0);
    check("mid_rst_hrdata", bus.HRDATA, 32'h0);

    xfer(32'h1F80_0020, 2'b10, 0, 32'h0, 2);
    xfer(32'h0000_0008, 2'b10, 0, 32'h0, 0);
    xfer(32'h4000_0000, 2'b10, 0, 32'h0, 0);
    xfer(32'h0000_0000, 2'b00, 0, 32'h0, 0);
    repeat (3) @(posedge HCLK);
    #1;
    check("drain", 32'(q.size()) + {31'h0, have}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
